// File: rtl/flash_adc_pkg.sv
// Shared definitions for the flash ADC front end: bubble correction, thermometer
// encoding, code-width helper and the result record used by display/UART blocks.
package flash_adc_pkg;

    localparam int MAX_LEVELS = 64;

    typedef logic [MAX_LEVELS-1:0] therm_t;

    typedef struct packed {
        logic [7:0]  code;
        logic [31:0] mv;
        logic        clip;
    } adc_result_t;

    function automatic int code_width(input int levels);
        return $clog2(levels + 1);
    endfunction

    // Unused upper bits must be zero so the bit above the top comparator reads as 0.
    function automatic therm_t bubble_correct(input therm_t s);
        logic [MAX_LEVELS+1:0] e;
        therm_t t;
        e = {1'b0, s, 1'b1};
        for (int i = 0; i < MAX_LEVELS; i++) begin
            t[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
        end
        return t;
    endfunction

    function automatic logic [7:0] therm_to_code(input therm_t t);
        logic [7:0] code;
        code = 8'd0;
        for (int i = 0; i < MAX_LEVELS; i++) begin
            if (t[i]) code = 8'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/flash_adc_sync.sv
// Multi-stage flip-flop synchroniser for an asynchronous bus.
module flash_adc_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/flash_adc_sampler.sv
// Flash ADC front end: synchronise, bubble-correct, encode, window-average and
// scale to mV, delivering each result over a valid/ready handshake.
module flash_adc_sampler
    import flash_adc_pkg::*;
#(
    parameter int LEVELS      = 8,
    parameter int VREF_MV     = 3300,
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MV_W        = 16,
    localparam int CW         = code_width(LEVELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEVELS-1:0] comp_in,
    input  logic              sample_en,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     code_out,
    output logic [MV_W-1:0]   mv_out,
    output logic              clip_out,
    output logic              overrun
);

    localparam int AW   = CW + AVG_LOG2;
    localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PW   = CW + $clog2(VREF_MV + 1);

    logic [LEVELS-1:0] s;
    therm_t            s_ext;
    therm_t            t;
    logic [7:0]        code_full;
    logic [CW-1:0]     code;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [CNTW-1:0]   cnt;
    logic              clip_flag;
    logic              clip_next;
    logic              last;
    logic [CW-1:0]     avg;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     mv_full;
    adc_result_t       nxt;

    flash_adc_sync #(
        .WIDTH (LEVELS),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (comp_in),
        .q    (s)
    );

    always_comb begin
        s_ext              = '0;
        s_ext[LEVELS-1:0]  = s;
        t                  = bubble_correct(s_ext);
        code_full          = therm_to_code(t);
        code               = code_full[CW-1:0];
        sum                = acc + AW'(code);
        clip_next          = clip_flag | (code == CW'(LEVELS));
        last               = (AVG_LOG2 == 0) || (cnt == CNTW'((1 << AVG_LOG2) - 1));
        avg                = CW'(sum >> AVG_LOG2);
        // Round-half-up scaling; divisor is a constant so this folds to a multiply.
        prod               = PW'(avg) * PW'(VREF_MV) + PW'(LEVELS / 2);
        mv_full            = prod / PW'(LEVELS);
        nxt.code           = 8'(avg);
        nxt.mv             = 32'(mv_full);
        nxt.clip           = clip_next;
    end

    // Handshake: a result transfers on any edge where out_valid && out_ready.
    // While out_valid is high and out_ready low, out_valid and all result fields
    // hold, unless a newer result completes, which overwrites and sets overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            clip_flag <= 1'b0;
            out_valid <= 1'b0;
            code_out  <= '0;
            mv_out    <= '0;
            clip_out  <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            cnt       <= '0;
            clip_flag <= 1'b0;
            out_valid <= 1'b0;
            code_out  <= '0;
            mv_out    <= '0;
            clip_out  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (sample_en) begin
                if (last) begin
                    acc       <= '0;
                    cnt       <= '0;
                    clip_flag <= 1'b0;
                    code_out  <= nxt.code[CW-1:0];
                    mv_out    <= nxt.mv[MV_W-1:0];
                    clip_out  <= nxt.clip;
                    out_valid <= 1'b1;
                    if (out_valid && !out_ready) overrun <= 1'b1;
                end else begin
                    acc       <= sum;
                    cnt       <= cnt + CNTW'(1);
                    clip_flag <= clip_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_adc_sampler.sv
// Directed bench for flash_adc_sampler: scoreboarded results for an averaging
// instance and a non-averaging instance, plus direct flag/hold checks.
module tb_flash_adc_sampler;

    logic       clk;
    logic       rst_n;
    logic [7:0] comp_in;
    logic       sample_en;
    logic       sample_en0;
    logic       clr;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] code_out;
    logic [15:0] mv_out;
    logic       clip_out;
    logic       overrun;
    logic       out_valid0;
    logic [3:0] code_out0;
    logic [15:0] mv_out0;
    logic       clip_out0;
    logic       overrun0;

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q[$];
    logic [20:0] exp0_q[$];

    flash_adc_sampler #(.LEVELS(8), .VREF_MV(3300), .AVG_LOG2(2), .SYNC_STAGES(2), .MV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .comp_in(comp_in), .sample_en(sample_en), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out), .mv_out(mv_out),
        .clip_out(clip_out), .overrun(overrun)
    );

    flash_adc_sampler #(.LEVELS(8), .VREF_MV(3300), .AVG_LOG2(0), .SYNC_STAGES(2), .MV_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .comp_in(comp_in), .sample_en(sample_en0), .clr(clr),
        .out_valid(out_valid0), .out_ready(1'b1), .code_out(code_out0), .mv_out(mv_out0),
        .clip_out(clip_out0), .overrun(overrun0)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] pack(input int code, input int mv, input logic clip);
        return {4'(code), 16'(mv), clip};
    endfunction

    // monitors
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", {11'd0, code_out, mv_out, clip_out}, 32'h1FFFFF);
            else check("result", {11'd0, code_out, mv_out, clip_out}, {11'd0, exp_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid0) begin
            if (exp0_q.size() == 0) check("unexpected_result0", {11'd0, code_out0, mv_out0, clip_out0}, 32'h1FFFFF);
            else check("result0", {11'd0, code_out0, mv_out0, clip_out0}, {11'd0, exp0_q.pop_front()});
        end
    end

    // driver tasks; all called at posedge + 1
    task automatic set_comp(input logic [7:0] v);
        comp_in = v;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        sample_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic pulse0();
        sample_en0 = 1'b1;
        @(posedge clk);
        #1;
        sample_en0 = 1'b0;
    endtask

    task automatic window_same(input logic [7:0] v, input int code, input int mv, input logic clip);
        exp_q.push_back(pack(code, mv, clip));
        set_comp(v);
        pulse(4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && exp0_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size() + exp0_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; comp_in = 8'h00; sample_en = 1'b0; sample_en0 = 1'b0;
        clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_code_out", code_out, 0);
        check("rst_mv_out", mv_out, 0);
        check("rst_clip_out", clip_out, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        window_same(8'h0F, 4, 1650, 1'b0);
        drain("drain_plain");
        window_same(8'h17, 4, 1650, 1'b0);
        drain("drain_bubble");
        window_same(8'h00, 0, 0, 1'b0);
        drain("drain_zero");

        // codes 1,2,3,4 -> avg 2
        exp_q.push_back(pack(2, 825, 1'b0));
        set_comp(8'h01); pulse(1);
        set_comp(8'h03); pulse(1);
        set_comp(8'h07); pulse(1);
        set_comp(8'h0F); pulse(1);
        drain("drain_ramp");

        // one full-scale sample in the window
        exp_q.push_back(pack(2, 825, 1'b1));
        set_comp(8'hFF); pulse(1);
        set_comp(8'h00); pulse(3);
        drain("drain_clip");

        // non-averaging instance
        exp0_q.push_back(pack(1, 413, 1'b0));
        set_comp(8'h01); pulse0();
        exp0_q.push_back(pack(8, 3300, 1'b1));
        set_comp(8'hFF); pulse0();
        drain("drain_avg0");

        // back-pressure: second result overwrites the held first one
        out_ready = 1'b0;
        set_comp(8'h0F); pulse(4);
        repeat (3) @(posedge clk);
        #1;
        check("hold_valid", out_valid, 1);
        check("hold_code", code_out, 4);
        check("hold_overrun", overrun, 0);
        set_comp(8'h03); pulse(4);
        check("ovr_valid", out_valid, 1);
        check("ovr_code", code_out, 2);
        check("ovr_mv", mv_out, 825);
        check("ovr_flag", overrun, 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_overrun", overrun, 0);
        check("clr_code", code_out, 0);
        out_ready = 1'b1;

        // reset mid-window loses the partial accumulation
        set_comp(8'h0F); pulse(2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(pack(2, 825, 1'b0));
        set_comp(8'h03); pulse(3);
        check("rst_partial_no_valid", out_valid, 0);
        pulse(1);
        drain("drain_reset");

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
